td4x_core: RTL and testbench

Parametrised successor to the 4-bit two-register teaching CPU: same A/B/carry/IP/output architecture and the same twelve base opcodes, generalised to W-bit data and AW-bit program address. It adds an instruction-fetch valid handshake (stall support for slow program memory), conditional jump on carry, a HALT state, and an optional hardware call/return stack. It sits between the program ROM (addr/instr) and board I/O (switches/LEDs).

---
 rtl/td4x_core.sv | 168 ++++++++++++++++
 tb/tb_td4x_core.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/td4x_core.sv
// td4x_core: parametrised two-register teaching CPU (A/B/CF/IP/OUT).
// Optional hardware call/return stack is enabled by defining TD4X_STACK_EN.
//
// Parameters:
//   W           data width of A, B, OUT, switch and immediate (W >= AW)
//   AW          program address width; IP wraps modulo 2^AW
//   STACK_DEPTH return-address entries (only used with TD4X_STACK_EN)
// Ports:
//   clk         clock, rising edge
//   n_reset     synchronous active-low reset
//   instr       instruction at addr (combinational ROM read)
//   instr_valid instr is valid this cycle; low stalls the core
//   switch      input port for IN A / IN B
//   addr        program address (IP register)
//   led         OUT register
//   halted      core is in HALT state
//   stack_err   sticky stack overflow/underflow flag
module td4x_core #(
  parameter int unsigned W           = 4,
  parameter int unsigned AW          = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic [4+W-1:0] instr,
  input  logic           instr_valid,
  input  logic [W-1:0]   switch,
  output logic [AW-1:0]  addr,
  output logic [W-1:0]   led,
  output logic           halted,
  output logic           stack_err
);

  localparam int unsigned IW = 4 + W;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_CALL   = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_RET    = 4'b1010;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JC     = 4'b1100;
  localparam logic [3:0] OP_HALT   = 4'b1101;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  out_q;
  logic          cf_q;
  logic [AW-1:0] ip_q;

  // Instruction decode
  logic [3:0]    op;
  logic [W-1:0]  imm;
  logic [AW-1:0] target;
  logic [AW-1:0] ip_inc;
  logic [W:0]    sum_a;
  logic [W:0]    sum_b;
  logic          exec;

  assign op     = instr[IW-1:IW-4];
  assign imm    = instr[W-1:0];
  assign target = imm[AW-1:0];
  assign ip_inc = ip_q + AW'(1);
  assign sum_a  = {1'b0, a_q} + {1'b0, imm};
  assign sum_b  = {1'b0, b_q} + {1'b0, imm};
  assign exec   = (state == S_RUN) && instr_valid;

  assign addr   = ip_q;
  assign led    = out_q;
  assign halted = (state == S_HALT);

`ifdef TD4X_STACK_EN
  localparam int unsigned SPW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SPW-1:0]  sp_q;
  logic            err_q;
  logic [AW-1:0]   stack_mem [STACK_DEPTH];
  logic            can_push;
  logic            can_pop;
  logic [IDXW-1:0] push_idx;
  logic [IDXW-1:0] pop_idx;

  assign can_push  = sp_q < SPW'(STACK_DEPTH);
  assign can_pop   = sp_q != '0;
  assign push_idx  = IDXW'(sp_q);
  assign pop_idx   = IDXW'(sp_q - SPW'(1));
  assign stack_err = err_q;

  // Return-address storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (n_reset && exec && (op == OP_CALL) && can_push) begin
      stack_mem[push_idx] <= ip_inc;
    end
  end
`else
  assign stack_err = 1'b0;
`endif

  // Core state machine and datapath
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= S_RUN;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      cf_q  <= 1'b0;
      ip_q  <= '0;
`ifdef TD4X_STACK_EN
      sp_q  <= '0;
      err_q <= 1'b0;
`endif
    end else if (exec) begin
      ip_q <= ip_inc;
      cf_q <= 1'b0;
      case (op)
        OP_ADD_A:  {cf_q, a_q} <= sum_a;
        OP_ADD_B:  {cf_q, b_q} <= sum_b;
        OP_MOV_A:  a_q   <= imm;
        OP_MOV_B:  b_q   <= imm;
        OP_MOV_AB: a_q   <= b_q;
        OP_MOV_BA: b_q   <= a_q;
        OP_IN_A:   a_q   <= switch;
        OP_IN_B:   b_q   <= switch;
        OP_OUT_B:  out_q <= b_q;
        OP_OUT_I:  out_q <= imm;
        OP_JMP:    ip_q  <= target;
        OP_JNC:    if (!cf_q) ip_q <= target;
        OP_JC:     if (cf_q) ip_q <= target;
        OP_HALT: begin
          state <= S_HALT;
          ip_q  <= ip_q;
        end
`ifdef TD4X_STACK_EN
        OP_CALL: begin
          if (can_push) begin
            sp_q <= sp_q + SPW'(1);
            ip_q <= target;
          end else begin
            err_q <= 1'b1;
          end
        end
        OP_RET: begin
          if (can_pop) begin
            sp_q <= sp_q - SPW'(1);
            ip_q <= stack_mem[pop_idx];
          end else begin
            err_q <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_td4x_core.sv
// Self-checking bench for td4x_core (W=4, AW=4, STACK_DEPTH=2).
// Each vector drives one cycle of inputs; the outputs expected after that
// edge are queued when driven and popped/compared #1 after the edge.
module tb_td4x_core;

  logic       clk;
  logic       n_reset;
  logic [7:0] instr;
  logic       instr_valid;
  logic [3:0] switch;
  logic [3:0] addr;
  logic [3:0] led;
  logic       halted;
  logic       stack_err;

  td4x_core #(.W(4), .AW(4), .STACK_DEPTH(2)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .switch      (switch),
    .addr        (addr),
    .led         (led),
    .halted      (halted),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [7:0] ins;
    logic [3:0] sw;
    logic [3:0] e_addr;
    logic [3:0] e_led;
    logic       e_halt;
    logic       e_err;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] e_addr;
    logic [3:0] e_led;
    logic       e_halt;
    logic       e_err;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   applied;
  int   miscompares;

  function automatic void v(input logic r, input logic vl, input logic [7:0] i,
                            input logic [3:0] s, input logic [3:0] ea,
                            input logic [3:0] el, input logic eh, input logic ee);
    vec_t t;
    t.rst_n = r; t.valid = vl; t.ins = i; t.sw = s;
    t.e_addr = ea; t.e_led = el; t.e_halt = eh; t.e_err = ee;
    vecs.push_back(t);
  endfunction

  initial begin
    exp_t e;
    applied     = 0;
    miscompares = 0;
    n_reset     = 1'b0;
    instr       = 8'h00;
    instr_valid = 1'b0;
    switch      = 4'h0;

    // Basic program: MOV A,1; ADD A,2; MOV B,A; OUT B; OUT 7; HALT
    v(0,1,8'h00,0, 4'h0,4'h0,0,0);
    v(1,1,8'h31,0, 4'h1,4'h0,0,0);
    v(1,1,8'h02,0, 4'h2,4'h0,0,0);
    v(1,1,8'h40,0, 4'h3,4'h0,0,0);
    v(1,1,8'h90,0, 4'h4,4'h3,0,0);
    v(1,1,8'hB7,0, 4'h5,4'h7,0,0);
    v(1,1,8'hD0,0, 4'h5,4'h7,1,0);
    v(1,1,8'hB2,0, 4'h5,4'h7,1,0);   // halted: OUT ignored
    v(1,0,8'h31,0, 4'h5,4'h7,1,0);
    v(0,1,8'hD0,0, 4'h0,4'h0,0,0);   // reset beats HALT
    // Carry and conditional jumps
    v(1,1,8'h31,0, 4'h1,4'h0,0,0);
    v(1,1,8'h0F,0, 4'h2,4'h0,0,0);   // A=0, CF=1
    v(1,1,8'hC8,0, 4'h8,4'h0,0,0);   // JC taken
    v(1,1,8'h40,0, 4'h9,4'h0,0,0);
    v(1,1,8'h90,0, 4'hA,4'h0,0,0);   // A was 0
    v(1,1,8'h31,0, 4'hB,4'h0,0,0);
    v(1,1,8'h0F,0, 4'hC,4'h0,0,0);   // CF=1
    v(1,1,8'hE8,0, 4'hD,4'h0,0,0);   // JNC not taken
    v(1,1,8'hC3,0, 4'hE,4'h0,0,0);   // JNC cleared CF: JC not taken
    v(1,1,8'hE3,0, 4'h3,4'h0,0,0);   // JNC taken
    // Stall after an overflowing ADD
    v(1,1,8'h3E,0, 4'h4,4'h0,0,0);
    v(1,1,8'h05,0, 4'h5,4'h0,0,0);   // A=3, CF=1
    for (int k = 0; k < 5; k++) v(1,0,8'hB9,0, 4'h5,4'h0,0,0);
    v(1,1,8'hCA,0, 4'hA,4'h0,0,0);   // CF survived the stall
    v(1,1,8'h40,0, 4'hB,4'h0,0,0);
    v(1,1,8'h90,0, 4'hC,4'h3,0,0);
    // IN, MOV, ADD B, wrap and JMP
    v(1,1,8'h20,6, 4'hD,4'h3,0,0);
    v(1,1,8'h60,9, 4'hE,4'h3,0,0);
    v(1,1,8'h90,0, 4'hF,4'h9,0,0);
    v(1,1,8'h41,0, 4'h0,4'h9,0,0);   // IP wraps
    v(1,1,8'h90,0, 4'h1,4'h6,0,0);
    v(1,1,8'h5F,0, 4'h2,4'h6,0,0);   // B=5, CF=1
    v(1,1,8'h90,0, 4'h3,4'h5,0,0);
    v(1,1,8'h7C,0, 4'h4,4'h5,0,0);
    v(1,1,8'h10,0, 4'h5,4'h5,0,0);
    v(1,1,8'h71,0, 4'h6,4'h5,0,0);
    v(1,1,8'h40,0, 4'h7,4'h5,0,0);
    v(1,1,8'h90,0, 4'h8,4'hC,0,0);
    v(1,1,8'hF2,0, 4'h2,4'hC,0,0);
`ifdef TD4X_STACK_EN
    v(1,1,8'h85,0, 4'h5,4'hC,0,0);
    v(1,1,8'hA0,0, 4'h3,4'hC,0,0);
    // Nested calls, overflow, underflow
    v(0,1,8'h00,0, 4'h0,4'h0,0,0);
    v(1,1,8'h85,0, 4'h5,4'h0,0,0);
    v(1,1,8'h89,0, 4'h9,4'h0,0,0);
    v(1,1,8'hA0,0, 4'h6,4'h0,0,0);
    v(1,1,8'hA0,0, 4'h1,4'h0,0,0);
    v(1,1,8'h84,0, 4'h4,4'h0,0,0);
    v(1,1,8'h88,0, 4'h8,4'h0,0,0);
    v(1,1,8'h8C,0, 4'h9,4'h0,0,1);   // full: no jump
    v(1,0,8'hA0,0, 4'h9,4'h0,0,1);   // stall: no pop
    v(1,1,8'hA0,0, 4'h5,4'h0,0,1);
    v(1,1,8'hA0,0, 4'h2,4'h0,0,1);
    v(1,1,8'hA0,0, 4'h3,4'h0,0,1);   // empty: no jump
    v(1,1,8'h31,0, 4'h4,4'h0,0,1);   // sticky
    v(0,1,8'h85,0, 4'h0,4'h0,0,0);
`else
    // CALL/RET are NOPs
    v(1,1,8'h85,0, 4'h3,4'hC,0,0);
    v(1,1,8'hA0,0, 4'h4,4'hC,0,0);
    v(0,1,8'h00,0, 4'h0,4'h0,0,0);
    v(1,1,8'h85,0, 4'h1,4'h0,0,0);
    v(1,1,8'h89,0, 4'h2,4'h0,0,0);
    v(1,1,8'hA0,0, 4'h3,4'h0,0,0);
    v(1,1,8'hA0,0, 4'h4,4'h0,0,0);
    v(1,1,8'h31,0, 4'h5,4'h0,0,0);
    v(1,1,8'h0F,0, 4'h6,4'h0,0,0);   // CF=1
    v(1,1,8'h80,0, 4'h7,4'h0,0,0);   // NOP clears CF
    v(1,1,8'hC0,0, 4'h8,4'h0,0,0);   // JC not taken
    v(0,1,8'h85,0, 4'h0,4'h0,0,0);
`endif

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      n_reset     = vecs[n].rst_n;
      instr_valid = vecs[n].valid;
      instr       = vecs[n].ins;
      switch      = vecs[n].sw;
      e.idx    = n;
      e.e_addr = vecs[n].e_addr;
      e.e_led  = vecs[n].e_led;
      e.e_halt = vecs[n].e_halt;
      e.e_err  = vecs[n].e_err;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      applied++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty vec %0d", n);
      end else begin
        e = exp_q.pop_front();
        if (addr !== e.e_addr || led !== e.e_led ||
            halted !== e.e_halt || stack_err !== e.e_err) begin
          miscompares++;
          $display("FAIL vec %0d: addr=%h led=%h halted=%b stack_err=%b, required addr=%h led=%h halted=%b stack_err=%b",
                   e.idx, addr, led, halted, stack_err,
                   e.e_addr, e.e_led, e.e_halt, e.e_err);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
